// File: rtl/fp_operand_prep_if.sv
// Handshake and operand/result bundle for fp_operand_prep.
// slave: the operand-prep block. master: the producer/consumer side.
interface fp_operand_prep_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic        comp;
  logic        magcheck;
  logic        zero;
  logic        A_sign;
  logic        B_sign;
  logic        mode;
  logic [7:0]  BigExp;
  logic [7:0]  SmallExp;
  logic [23:0] BigMan;
  logic [23:0] SmallMan;
  logic        special;
  logic [15:0] op_count;

  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready,
    output in_ready, out_valid, comp, magcheck, zero, A_sign, B_sign, mode,
           BigExp, SmallExp, BigMan, SmallMan, special, op_count
  );

  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready,
    input  in_ready, out_valid, comp, magcheck, zero, A_sign, B_sign, mode,
           BigExp, SmallExp, BigMan, SmallMan, special, op_count
  );
endinterface

// File: rtl/fp_operand_prep.sv
// Operand preparation for a single-precision adder: unpacks both operands,
// flushes denormals, compares magnitudes and orders them into Big/Small.
// Two-stage valid/ready pipeline, one pair per cycle under continuous flow.
module fp_operand_prep (
  input  logic               clk,
  input  logic               rst_n,
  fp_operand_prep_if.slave   bus
);

  // Mantissa with hidden bit; a zero exponent flushes the operand to 0.
  function automatic logic [23:0] unpack_man(input logic [31:0] op);
    return (op[30:23] == 8'h00) ? 24'h0 : {1'b1, op[22:0]};
  endfunction

  // Transfer counter that sticks at all-ones.
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic        r_vld_p1;
  logic [7:0]  r_exp_a_p1;
  logic [7:0]  r_exp_b_p1;
  logic [23:0] r_man_a_p1;
  logic [23:0] r_man_b_p1;
  logic        r_sign_a_p1;
  logic        r_sign_b_p1;
  logic        r_mode_p1;
  logic        r_special_p1;
  logic        r_comp_p1;
  logic        r_mag_p1;
  logic        r_zero_p1;

  logic        r_vld_p2;
  logic [7:0]  r_big_exp_p2;
  logic [7:0]  r_small_exp_p2;
  logic [23:0] r_big_man_p2;
  logic [23:0] r_small_man_p2;
  logic        r_sign_a_p2;
  logic        r_sign_b_p2;
  logic        r_mode_p2;
  logic        r_special_p2;
  logic        r_comp_p2;
  logic        r_mag_p2;
  logic        r_zero_p2;
  logic [15:0] r_op_count;

  logic [7:0]  w_exp_a;
  logic [7:0]  w_exp_b;
  logic [23:0] w_man_a;
  logic [23:0] w_man_b;
  logic        w_s2_en;
  logic        w_in_ready;
  logic        w_a_big;
  logic        w_xfer;

  // A flushed operand reports exponent 0 regardless of its fraction bits.
  assign w_exp_a    = bus.in_a[30:23];
  assign w_exp_b    = bus.in_b[30:23];
  assign w_man_a    = unpack_man(bus.in_a);
  assign w_man_b    = unpack_man(bus.in_b);

  // S2 can load when empty or its content leaves this cycle; S1 likewise.
  assign w_s2_en    = ~r_vld_p2 | bus.out_ready;
  assign w_in_ready = ~r_vld_p1 | w_s2_en;
  assign w_a_big    = r_comp_p1 | r_mag_p1 | r_zero_p1;
  assign w_xfer     = r_vld_p2 & bus.out_ready;

  // Stage 1: unpack, flush and compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1     <= 1'b0;
      r_exp_a_p1   <= '0;
      r_exp_b_p1   <= '0;
      r_man_a_p1   <= '0;
      r_man_b_p1   <= '0;
      r_sign_a_p1  <= 1'b0;
      r_sign_b_p1  <= 1'b0;
      r_mode_p1    <= 1'b0;
      r_special_p1 <= 1'b0;
      r_comp_p1    <= 1'b0;
      r_mag_p1     <= 1'b0;
      r_zero_p1    <= 1'b0;
    end else begin
      if (w_in_ready) r_vld_p1 <= bus.in_valid;
      if (w_in_ready & bus.in_valid) begin
        r_exp_a_p1   <= w_exp_a;
        r_exp_b_p1   <= w_exp_b;
        r_man_a_p1   <= w_man_a;
        r_man_b_p1   <= w_man_b;
        r_sign_a_p1  <= bus.in_a[31];
        r_sign_b_p1  <= bus.in_b[31];
        r_mode_p1    <= bus.in_mode;
        r_special_p1 <= (w_exp_a == 8'hFF) | (w_exp_b == 8'hFF);
        r_comp_p1    <= (w_exp_a > w_exp_b);
        r_mag_p1     <= (w_exp_a == w_exp_b) & (w_man_a > w_man_b);
        r_zero_p1    <= (w_exp_a == w_exp_b) & (w_man_a == w_man_b);
      end
    end
  end

  // Stage 2: swap into Big/Small; held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2       <= 1'b0;
      r_big_exp_p2   <= '0;
      r_small_exp_p2 <= '0;
      r_big_man_p2   <= '0;
      r_small_man_p2 <= '0;
      r_sign_a_p2    <= 1'b0;
      r_sign_b_p2    <= 1'b0;
      r_mode_p2      <= 1'b0;
      r_special_p2   <= 1'b0;
      r_comp_p2      <= 1'b0;
      r_mag_p2       <= 1'b0;
      r_zero_p2      <= 1'b0;
    end else begin
      if (w_s2_en) r_vld_p2 <= r_vld_p1;
      if (w_s2_en & r_vld_p1) begin
        r_big_exp_p2   <= w_a_big ? r_exp_a_p1 : r_exp_b_p1;
        r_small_exp_p2 <= w_a_big ? r_exp_b_p1 : r_exp_a_p1;
        r_big_man_p2   <= w_a_big ? r_man_a_p1 : r_man_b_p1;
        r_small_man_p2 <= w_a_big ? r_man_b_p1 : r_man_a_p1;
        r_sign_a_p2    <= r_sign_a_p1;
        r_sign_b_p2    <= r_sign_b_p1;
        r_mode_p2      <= r_mode_p1;
        r_special_p2   <= r_special_p1;
        r_comp_p2      <= r_comp_p1;
        r_mag_p2       <= r_mag_p1;
        r_zero_p2      <= r_zero_p1;
      end
    end
  end

  // Count completed output transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_op_count <= '0;
    else if (w_xfer) r_op_count <= sat_inc(r_op_count);
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_vld_p2;
  assign bus.comp      = r_comp_p2;
  assign bus.magcheck  = r_mag_p2;
  assign bus.zero      = r_zero_p2;
  assign bus.A_sign    = r_sign_a_p2;
  assign bus.B_sign    = r_sign_b_p2;
  assign bus.mode      = r_mode_p2;
  assign bus.BigExp    = r_big_exp_p2;
  assign bus.SmallExp  = r_small_exp_p2;
  assign bus.BigMan    = r_big_man_p2;
  assign bus.SmallMan  = r_small_man_p2;
  assign bus.special   = r_special_p2;
  assign bus.op_count  = r_op_count;

endmodule

// File: tb/tb_fp_operand_prep.sv
// Bench for fp_operand_prep: directed checks of the worked examples, a
// stalled back-to-back burst, randomized traffic against a magnitude-based
// reference model, and reset asserted while both stages hold data.
module tb_fp_operand_prep;

  typedef struct packed {
    logic        comp;
    logic        magcheck;
    logic        zero;
    logic        a_sign;
    logic        b_sign;
    logic        mode;
    logic        special;
    logic [7:0]  bexp;
    logic [7:0]  sexp;
    logic [23:0] bman;
    logic [23:0] sman;
  } res_t;

  logic clk;
  logic rst_n;
  fp_operand_prep_if bus();

  fp_operand_prep dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_xfer = 0;
  logic last_acc;
  logic last_stall;
  res_t last_snap;
  res_t exp_q[$];
  res_t got_q[$];

  // Reference: an operand is a sign plus an unsigned magnitude {exp, man};
  // the larger magnitude (A on a tie) becomes Big.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic m);
    res_t r;
    int unsigned ea, eb, ma, mb, maga, magb;
    ea = a[30:23];
    eb = b[30:23];
    ma = (ea == 0) ? 0 : (32'h800000 + a[22:0]);
    mb = (eb == 0) ? 0 : (32'h800000 + b[22:0]);
    maga = ea * 32'h1000000 + ma;
    magb = eb * 32'h1000000 + mb;
    r.comp     = (ea > eb);
    r.magcheck = (ea == eb) && (ma > mb);
    r.zero     = (ea == eb) && (ma == mb);
    r.a_sign   = a[31];
    r.b_sign   = b[31];
    r.mode     = m;
    r.special  = (ea == 255) || (eb == 255);
    if (maga >= magb) begin
      r.bexp = 8'(ea); r.bman = 24'(ma); r.sexp = 8'(eb); r.sman = 24'(mb);
    end else begin
      r.bexp = 8'(eb); r.bman = 24'(mb); r.sexp = 8'(ea); r.sman = 24'(ma);
    end
    return r;
  endfunction

  function automatic res_t snap();
    res_t r;
    r.comp = bus.comp;       r.magcheck = bus.magcheck; r.zero = bus.zero;
    r.a_sign = bus.A_sign;   r.b_sign = bus.B_sign;     r.mode = bus.mode;
    r.special = bus.special; r.bexp = bus.BigExp;       r.sexp = bus.SmallExp;
    r.bman = bus.BigMan;     r.sman = bus.SmallMan;
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    v = $urandom();
    case ($urandom_range(0, 7))
      0: v[30:23] = 8'h00;
      1: v[30:23] = 8'hFF;
      default: ;
    endcase
    return v;
  endfunction

  // One clock: record handshakes at the falling edge, return 1 after the rising edge.
  task automatic cycle();
    @(negedge clk);
    last_acc   = bus.in_valid & bus.in_ready;
    last_stall = bus.out_valid & ~bus.out_ready;
    last_snap  = snap();
    if (last_acc) exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_mode));
    if (bus.out_valid & bus.out_ready) begin
      got_q.push_back(snap());
      n_xfer++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    got_q.delete();
    n_xfer = 0;
  endtask

  // Offer one pair with the consumer stalled; returns out_valid one cycle
  // after the accept and leaves the bench two cycles after the accept.
  task automatic offer(input logic [31:0] a, input logic [31:0] b, input logic m,
                       output logic ov1, output logic acc);
    bus.out_ready = 1'b0;
    bus.in_a = a; bus.in_b = b; bus.in_mode = m; bus.in_valid = 1'b1;
    cycle();
    acc = last_acc;
    bus.in_valid = 1'b0;
    ov1 = bus.out_valid;
    cycle();
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.op_count !== 16'h0) begin n_fail++; $display("FAIL reset_op_count got %h want 0", bus.op_count); end
    n_cmp++; if (snap() !== res_t'(0)) begin n_fail++; $display("FAIL reset_data got %h want 0", snap()); end
    rst_n = 1'b1;
    cycle();
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_add_basic();
    logic ov1, acc;
    res_t r;
    offer(32'h40400000, 32'h3F800000, 1'b0, ov1, acc);
    r = snap();
    n_cmp++; if (acc !== 1'b1) begin n_fail++; $display("FAIL add_accept got %b want 1", acc); end
    n_cmp++; if (ov1 !== 1'b0 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL add_latency got %b%b want 01", ov1, bus.out_valid); end
    n_cmp++; if ({r.comp, r.magcheck, r.zero} !== 3'b100) begin n_fail++; $display("FAIL add_flags got %b want 100", {r.comp, r.magcheck, r.zero}); end
    n_cmp++; if ({r.bexp, r.bman, r.sexp, r.sman} !== {8'h80, 24'hC00000, 8'h7F, 24'h800000}) begin
      n_fail++; $display("FAIL add_fields got %h want %h", {r.bexp, r.bman, r.sexp, r.sman}, {8'h80, 24'hC00000, 8'h7F, 24'h800000}); end
    consume();
  endtask

  task automatic test_sub_swap();
    logic ov1, acc;
    res_t r;
    offer(32'h3F800000, 32'hC0400000, 1'b1, ov1, acc);
    r = snap();
    n_cmp++; if (r.comp !== 1'b0) begin n_fail++; $display("FAIL sub_comp got %b want 0", r.comp); end
    n_cmp++; if ({r.bexp, r.bman, r.sman} !== {8'h80, 24'hC00000, 24'h800000}) begin
      n_fail++; $display("FAIL sub_fields got %h want %h", {r.bexp, r.bman, r.sman}, {8'h80, 24'hC00000, 24'h800000}); end
    n_cmp++; if ({r.a_sign, r.b_sign, r.mode} !== 3'b011) begin n_fail++; $display("FAIL sub_signs got %b want 011", {r.a_sign, r.b_sign, r.mode}); end
    consume();
  endtask

  task automatic test_magcheck_zero();
    logic ov1, acc;
    res_t r;
    offer(32'h3FC00000, 32'h3F800000, 1'b0, ov1, acc);
    r = snap();
    n_cmp++; if ({r.comp, r.magcheck, r.zero, r.bman, r.sman} !== {3'b010, 24'hC00000, 24'h800000}) begin
      n_fail++; $display("FAIL magcheck got %h want %h", {r.comp, r.magcheck, r.zero, r.bman, r.sman}, {3'b010, 24'hC00000, 24'h800000}); end
    consume();
    offer(32'h3F800000, 32'hBF800000, 1'b1, ov1, acc);
    r = snap();
    n_cmp++; if ({r.comp, r.magcheck, r.zero, r.bexp, r.bman} !== {3'b001, 8'h7F, 24'h800000}) begin
      n_fail++; $display("FAIL zero_eq got %h want %h", {r.comp, r.magcheck, r.zero, r.bexp, r.bman}, {3'b001, 8'h7F, 24'h800000}); end
    n_cmp++; if (r !== model(32'h3F800000, 32'hBF800000, 1'b1)) begin
      n_fail++; $display("FAIL zero_model got %h want %h", r, model(32'h3F800000, 32'hBF800000, 1'b1)); end
    consume();
  endtask

  task automatic test_denormal_special();
    logic ov1, acc;
    res_t r;
    offer(32'h00400000, 32'h7F800000, 1'b0, ov1, acc);
    r = snap();
    n_cmp++; if ({r.sexp, r.sman} !== 32'h0) begin n_fail++; $display("FAIL denorm_flush got %h want 0", {r.sexp, r.sman}); end
    n_cmp++; if ({r.special, r.bexp, r.bman} !== {1'b1, 8'hFF, 24'h800000}) begin
      n_fail++; $display("FAIL special got %h want %h", {r.special, r.bexp, r.bman}, {1'b1, 8'hFF, 24'h800000}); end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pa[3];
    logic [31:0] pb[3];
    res_t s0;
    int k;
    apply_reset();
    for (int i = 0; i < 3; i++) begin pa[i] = rand_op(); pb[i] = rand_op(); end
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_a = pa[i]; bus.in_b = pb[i]; bus.in_mode = i[0]; bus.in_valid = 1'b1;
      cycle();
    end
    n_cmp++; if (exp_q.size() != 2 || last_acc !== 1'b0) begin n_fail++; $display("FAIL b2b_accepted got %0d want 2", exp_q.size()); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready got %b want 0", bus.in_ready); end
    s0 = snap();
    repeat (3) cycle();
    n_cmp++; if (snap() !== s0 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_stable got %h want %h", snap(), s0); end
    bus.out_ready = 1'b1;
    k = 0;
    while (got_q.size() < 3 && k < 20) begin
      cycle();
      if (last_acc) bus.in_valid = 1'b0;
      k++;
    end
    bus.in_valid = 1'b0;
    n_cmp++; if (got_q.size() != 3 || exp_q.size() != 3) begin n_fail++; $display("FAIL b2b_count got %0d want 3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_order[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (bus.op_count !== 16'd3) begin n_fail++; $display("FAIL b2b_op_count got %0d want 3", bus.op_count); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random();
    int k;
    exp_q.delete(); got_q.delete();
    for (int c = 0; c < 3000; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_mode   = 1'($urandom());
      bus.in_a      = rand_op();
      case ($urandom_range(0, 3))
        0: bus.in_b = {~bus.in_a[31], bus.in_a[30:0]};
        1: bus.in_b = {1'($urandom()), bus.in_a[30:23], 23'($urandom())};
        default: bus.in_b = rand_op();
      endcase
      cycle();
      if (last_stall) begin
        n_cmp++; if (snap() !== last_snap || bus.out_valid !== 1'b1) begin
          n_fail++; $display("FAIL rand_hold got %h want %h", snap(), last_snap); end
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    k = 0;
    while ((bus.out_valid === 1'b1 || got_q.size() < exp_q.size()) && k < 20) begin cycle(); k++; end
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_data[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (bus.op_count !== 16'(n_xfer)) begin n_fail++; $display("FAIL rand_op_count got %0d want %0d", bus.op_count, n_xfer); end
    bus.out_ready = 1'b0;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_midop();
    logic ov1, acc;
    res_t want;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_a = rand_op(); bus.in_b = rand_op(); bus.in_valid = 1'b1;
      cycle();
    end
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL midop_full got %b%b want 10", bus.out_valid, bus.in_ready); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.op_count !== 16'h0) begin
      n_fail++; $display("FAIL midop_clear got valid %b count %0d want 0 0", bus.out_valid, bus.op_count); end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete(); got_q.delete(); n_xfer = 0;
    bus.out_ready = 1'b1;
    repeat (5) cycle();
    n_cmp++; if (got_q.size() != 0 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midop_stale got %0d outputs want 0", got_q.size()); end
    want = model(32'h41200000, 32'hC1200001, 1'b1);
    offer(32'h41200000, 32'hC1200001, 1'b1, ov1, acc);
    n_cmp++; if (acc !== 1'b1 || ov1 !== 1'b0 || bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL midop_first got %b%b%b want 101", acc, ov1, bus.out_valid); end
    n_cmp++; if (snap() !== want) begin n_fail++; $display("FAIL midop_data got %h want %h", snap(), want); end
    consume();
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_sub_swap();
    test_magcheck_zero();
    test_denormal_special();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
